// File: rtl/load_store_unit.sv
// Load/store unit bridging a pipeline request port to a single-ported, registered-read memory.
// Sub-word stores use a read-modify-write sequence. Misaligned, reserved-size and ROM-store requests are rejected.
module load_store_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        reqValid,
    output logic        reqReady,
    input  logic        reqWrite,
    input  logic [1:0]  reqSize,
    input  logic        reqUnsigned,
    input  logic [31:0] reqAddress,
    input  logic [31:0] reqWriteData,
    output logic        respValid,
    output logic [31:0] respData,
    output logic        respError,
    output logic [31:0] memAddress,
    output logic        memReadWrite,
    output logic [31:0] memWriteData,
    input  logic [31:0] memReadData
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        WAIT  = 3'd2,
        WRITE = 3'd3,
        RESP  = 3'd4
    } state_t;

    state_t      state_r;
    logic        write_r;
    logic [1:0]  size_r;
    logic        unsigned_r;
    logic [1:0]  lane_r;
    logic [15:0] wdata_r;
    logic        req_err_s;

    // Requests are rejected for a reserved size, misalignment, or a store below the RAM window (addr[10] = 0).
    function automatic logic access_error(input logic write, input logic [1:0] size,
                                          input logic [1:0] lane, input logic ram_bit);
        logic err;
        case (size)
            2'b00:   err = 1'b0;
            2'b01:   err = lane[0];
            2'b10:   err = (lane != 2'b00);
            default: err = 1'b1;
        endcase
        if (write && !ram_bit) begin
            err = 1'b1;
        end else begin
            err = err;
        end
        return err;
    endfunction

    function automatic logic [31:0] load_extract(input logic [1:0] size, input logic uns,
                                                 input logic [1:0] lane, input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (lane)
            2'b00:   b = word[7:0];
            2'b01:   b = word[15:8];
            2'b10:   b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   res = uns ? {24'h000000, b} : {{24{b[7]}}, b};
            2'b01:   res = uns ? {16'h0000, h} : {{16{h[15]}}, h};
            default: res = word;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] store_merge(input logic [1:0] size, input logic [1:0] lane,
                                                input logic [15:0] wd, input logic [31:0] word);
        logic [31:0] mask;
        logic [31:0] data;
        case (size)
            2'b00: begin
                mask = 32'h000000FF << {lane, 3'b000};
                data = {24'h000000, wd[7:0]} << {lane, 3'b000};
            end
            2'b01: begin
                mask = 32'h0000FFFF << {lane[1], 4'b0000};
                data = {16'h0000, wd} << {lane[1], 4'b0000};
            end
            default: begin
                mask = 32'h00000000;
                data = 32'h00000000;
            end
        endcase
        return (word & ~mask) | (data & mask);
    endfunction

    assign req_err_s = access_error(reqWrite, reqSize, reqAddress[1:0], reqAddress[10]);

    // Transaction FSM; every output is registered and set on the edge entering the state that presents it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r      <= IDLE;
            write_r      <= 1'b0;
            size_r       <= 2'b00;
            unsigned_r   <= 1'b0;
            lane_r       <= 2'b00;
            wdata_r      <= 16'h0000;
            reqReady     <= 1'b1;
            respValid    <= 1'b0;
            respData     <= 32'h00000000;
            respError    <= 1'b0;
            memAddress   <= 32'h00000000;
            memReadWrite <= 1'b0;
            memWriteData <= 32'h00000000;
        end else begin
            case (state_r)
                IDLE: begin
                    if (reqValid) begin
                        write_r    <= reqWrite;
                        size_r     <= reqSize;
                        unsigned_r <= reqUnsigned;
                        lane_r     <= reqAddress[1:0];
                        wdata_r    <= reqWriteData[15:0];
                        reqReady   <= 1'b0;
                        if (req_err_s) begin
                            state_r   <= RESP;
                            respValid <= 1'b1;
                            respError <= 1'b1;
                            respData  <= 32'h00000000;
                        end else if (reqWrite && (reqSize == 2'b10)) begin
                            state_r      <= WRITE;
                            memAddress   <= {reqAddress[31:2], 2'b00};
                            memReadWrite <= 1'b1;
                            memWriteData <= reqWriteData;
                        end else begin
                            state_r    <= READ;
                            memAddress <= {reqAddress[31:2], 2'b00};
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                READ: begin
                    state_r <= WAIT;
                end
                WAIT: begin
                    if (write_r) begin
                        state_r      <= WRITE;
                        memReadWrite <= 1'b1;
                        memWriteData <= store_merge(size_r, lane_r, wdata_r, memReadData);
                    end else begin
                        state_r   <= RESP;
                        respValid <= 1'b1;
                        respError <= 1'b0;
                        respData  <= load_extract(size_r, unsigned_r, lane_r, memReadData);
                    end
                end
                WRITE: begin
                    state_r      <= RESP;
                    memReadWrite <= 1'b0;
                    respValid    <= 1'b1;
                    respError    <= 1'b0;
                    respData     <= 32'h00000000;
                end
                RESP: begin
                    state_r   <= IDLE;
                    reqReady  <= 1'b1;
                    respValid <= 1'b0;
                    respError <= 1'b0;
                    respData  <= 32'h00000000;
                end
                default: begin
                    state_r      <= IDLE;
                    reqReady     <= 1'b1;
                    respValid    <= 1'b0;
                    respError    <= 1'b0;
                    respData     <= 32'h00000000;
                    memReadWrite <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a registered-read memory model and hand-computed expectations.
module tb_load_store_unit;

    logic        clk;
    logic        reset;
    logic        reqValid;
    logic        reqReady;
    logic        reqWrite;
    logic [1:0]  reqSize;
    logic        reqUnsigned;
    logic [31:0] reqAddress;
    logic [31:0] reqWriteData;
    logic        respValid;
    logic [31:0] respData;
    logic        respError;
    logic [31:0] memAddress;
    logic        memReadWrite;
    logic [31:0] memWriteData;
    logic [31:0] memReadData;

    logic [31:0] mem [0:1023];
    int          wr_count;
    int          resp_count;
    logic [31:0] last_wr_addr;
    logic [31:0] last_wr_data;

    int          n_cmp;
    int          n_fail;
    int          lat_g;
    int          wr_delta_g;
    logic [31:0] data_g;
    logic        err_g;

    load_store_unit dut (
        .clk          (clk),
        .reset        (reset),
        .reqValid     (reqValid),
        .reqReady     (reqReady),
        .reqWrite     (reqWrite),
        .reqSize      (reqSize),
        .reqUnsigned  (reqUnsigned),
        .reqAddress   (reqAddress),
        .reqWriteData (reqWriteData),
        .respValid    (respValid),
        .respData     (respData),
        .respError    (respError),
        .memAddress   (memAddress),
        .memReadWrite (memReadWrite),
        .memWriteData (memWriteData),
        .memReadData  (memReadData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: registered read data, write on a clock where memReadWrite is high.
    always @(posedge clk) begin
        memReadData <= mem[memAddress[11:2]];
        if (memReadWrite) begin
            mem[memAddress[11:2]] <= memWriteData;
            wr_count     <= wr_count + 1;
            last_wr_addr <= memAddress;
            last_wr_data <= memWriteData;
        end
        if (respValid) begin
            resp_count <= resp_count + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request and wait (bounded) for the response pulse; latency counts cycles after the accept edge.
    task automatic run_req(input logic w, input logic [1:0] sz, input logic u,
                           input logic [31:0] a, input logic [31:0] wd, input logic hold);
        int wr0;
        @(negedge clk);
        reqValid     = 1'b1;
        reqWrite     = w;
        reqSize      = sz;
        reqUnsigned  = u;
        reqAddress   = a;
        reqWriteData = wd;
        wr0          = wr_count;
        @(posedge clk);
        #1;
        if (!hold) reqValid = 1'b0;
        lat_g = 0;
        do begin
            @(negedge clk);
            lat_g++;
        end while (!respValid && lat_g < 8);
        data_g     = respData;
        err_g      = respError;
        reqValid   = 1'b0;
        @(negedge clk);
        wr_delta_g = wr_count - wr0;
    endtask

    initial begin
        int r0;
        int w0;
        n_cmp        = 0;
        n_fail       = 0;
        wr_count     = 0;
        resp_count   = 0;
        last_wr_addr = 32'h0;
        last_wr_data = 32'h0;
        reset        = 1'b0;
        reqValid     = 1'b0;
        reqWrite     = 1'b0;
        reqSize      = 2'b00;
        reqUnsigned  = 1'b0;
        reqAddress   = 32'h0;
        reqWriteData = 32'h0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[32'h404 >> 2] = 32'h80FF1234;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_reqReady", {31'h0, reqReady}, 32'h1);
        check("rst_respValid", {31'h0, respValid}, 32'h0);
        check("rst_respData", respData, 32'h0);
        check("rst_respError", {31'h0, respError}, 32'h0);
        check("rst_memAddress", memAddress, 32'h0);
        check("rst_memReadWrite", {31'h0, memReadWrite}, 32'h0);
        check("rst_memWriteData", memWriteData, 32'h0);
        reset = 1'b1;

        // Load word with reqValid held high while busy: must not be re-accepted.
        r0 = resp_count;
        run_req(1'b0, 2'b10, 1'b0, 32'h404, 32'h0, 1'b1);
        check("lw_lat", lat_g, 32'd3);
        check("lw_data", data_g, 32'h80FF1234);
        check("lw_err", {31'h0, err_g}, 32'h0);
        check("lw_nowrite", wr_delta_g, 32'd0);
        check("lw_ready_after", {31'h0, reqReady}, 32'h1);
        check("lw_resp_pulses", resp_count - r0, 32'd1);

        run_req(1'b0, 2'b00, 1'b0, 32'h407, 32'h0, 1'b0);
        check("lb_s_lat", lat_g, 32'd3);
        check("lb_s_data", data_g, 32'hFFFFFF80);
        run_req(1'b0, 2'b00, 1'b1, 32'h407, 32'h0, 1'b0);
        check("lb_u_data", data_g, 32'h00000080);
        run_req(1'b0, 2'b00, 1'b0, 32'h405, 32'h0, 1'b0);
        check("lb_s_pos", data_g, 32'h00000012);
        run_req(1'b0, 2'b01, 1'b0, 32'h406, 32'h0, 1'b0);
        check("lh_s_data", data_g, 32'hFFFF80FF);
        run_req(1'b0, 2'b01, 1'b1, 32'h404, 32'h0, 1'b0);
        check("lh_u_data", data_g, 32'h00001234);

        // Halfword store read-modify-write.
        mem[32'h404 >> 2] = 32'h11223344;
        run_req(1'b1, 2'b01, 1'b0, 32'h406, 32'h1234BEEF, 1'b0);
        check("sh_lat", lat_g, 32'd4);
        check("sh_writes", wr_delta_g, 32'd1);
        check("sh_wr_addr", last_wr_addr, 32'h404);
        check("sh_wr_data", last_wr_data, 32'hBEEF3344);
        check("sh_resp_data", data_g, 32'h0);
        check("sh_err", {31'h0, err_g}, 32'h0);
        run_req(1'b1, 2'b00, 1'b0, 32'h405, 32'h777777A5, 1'b0);
        check("sb_wr_data", last_wr_data, 32'hBEEFA544);
        run_req(1'b0, 2'b10, 1'b0, 32'h404, 32'h0, 1'b0);
        check("lw_after_st", data_g, 32'hBEEFA544);

        run_req(1'b1, 2'b10, 1'b0, 32'h408, 32'hCAFEF00D, 1'b0);
        check("sw_lat", lat_g, 32'd2);
        check("sw_writes", wr_delta_g, 32'd1);
        check("sw_wr_addr", last_wr_addr, 32'h408);
        check("sw_wr_data", last_wr_data, 32'hCAFEF00D);

        // Error cases: one-cycle latency, error flag, no memory write.
        run_req(1'b1, 2'b10, 1'b0, 32'h010, 32'h12345678, 1'b0);
        check("err_rom_lat", lat_g, 32'd1);
        check("err_rom_flag", {31'h0, err_g}, 32'h1);
        check("err_rom_data", data_g, 32'h0);
        check("err_rom_nowrite", wr_delta_g, 32'd0);
        run_req(1'b0, 2'b10, 1'b0, 32'h402, 32'h0, 1'b0);
        check("err_mis_lat", lat_g, 32'd1);
        check("err_mis_flag", {31'h0, err_g}, 32'h1);
        check("err_mis_nowrite", wr_delta_g, 32'd0);
        run_req(1'b0, 2'b11, 1'b0, 32'h404, 32'h0, 1'b0);
        check("err_rsv_lat", lat_g, 32'd1);
        check("err_rsv_flag", {31'h0, err_g}, 32'h1);
        check("err_rsv_data", data_g, 32'h0);
        run_req(1'b0, 2'b01, 1'b0, 32'h405, 32'h0, 1'b0);
        check("err_half_flag", {31'h0, err_g}, 32'h1);
        run_req(1'b1, 2'b00, 1'b0, 32'h00C, 32'h0, 1'b0);
        check("err_rom_byte", {31'h0, err_g}, 32'h1);
        check("err_rom_byte_nw", wr_delta_g, 32'd0);

        // Reset during WAIT of a byte store aborts it.
        w0 = wr_count;
        r0 = resp_count;
        @(negedge clk);
        reqValid     = 1'b1;
        reqWrite     = 1'b1;
        reqSize      = 2'b00;
        reqUnsigned  = 1'b0;
        reqAddress   = 32'h40C;
        reqWriteData = 32'h000000AA;
        @(posedge clk);
        #1;
        reqValid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("abort_ready", {31'h0, reqReady}, 32'h1);
        check("abort_rw", {31'h0, memReadWrite}, 32'h0);
        check("abort_respValid", {31'h0, respValid}, 32'h0);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        check("abort_no_write", wr_count - w0, 32'd0);
        check("abort_no_resp", resp_count - r0, 32'd0);
        run_req(1'b0, 2'b10, 1'b0, 32'h404, 32'h0, 1'b0);
        check("post_abort_lat", lat_g, 32'd3);
        check("post_abort_data", data_g, 32'hBEEFA544);
        check("post_abort_err", {31'h0, err_g}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
